// File: rtl/cpu_pkg.sv
// Shared fetch-side types and constants for the CPU front end.
// Pure definitions; no timing.
// Imported by fetch_stage and fetch_skid_buf.
package cpu_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  // All-zero word decodes as SLL r0,r0,0, i.e. a harmless bubble.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} park slot for a fetched word that arrives while IF/ID is stalled.
// Latency: push visible on full_o/instr_o/pc_o the edge after push_i.
// Backpressure: caller must not push while full; clear_i wins over push_i, push_i over pop_i.
module fetch_skid_buf
  import cpu_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic               full_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o
);

  logic               full_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_q;

  // Occupancy and payload; a cleared entry keeps stale payload since full_q gates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end else if (push_i) begin
      full_q  <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch (PC + req/gnt/rvalid port) feeding the IF/ID pipeline register. FETCH_PERF_EN adds perf counters.
// Latency: IF/ID loads the edge after rvalid; 1 instruction per 2 cycles with a 1-cycle memory.
// Backpressure: stall parks one word in the skid and suppresses new requests until it drains.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              if_id_valid,
  output logic [31:0]       if_id_instr,
  output logic [PC_W-1:0]   if_id_pc,
  output logic [PC_W-1:0]   if_id_pc4,
  output logic [5:0]        opcode,
  output logic [5:0]        funct
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  fetch_state_t        state_q;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                drop_q;

  logic                valid_q;
  logic [INSTR_W-1:0]  instr_q;
  logic [PC_W-1:0]     if_pc_q, if_pc4_q;

  logic                skid_full;
  logic [INSTR_W-1:0]  skid_instr;
  logic [PC_W-1:0]     skid_pc;

  logic                deliver, skid_push, skid_pop, skid_clr;
  logic [PC_W-1:0]     redirect_tgt;

  assign redirect_tgt = redirect_pc & ~PC_W'(3);

  // A returning word is kept only if it was not cancelled earlier or by a redirect this cycle.
  assign deliver   = (state_q == WAIT) && imem_rvalid && !drop_q && !redirect;
  assign skid_push = deliver && stall && !flush;
  assign skid_clr  = flush || redirect;
  assign skid_pop  = skid_full && !stall && !skid_clr;

  // Next PC: redirect wins, otherwise advance past each kept word.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_tgt;
    end else if (deliver) begin
      pc_d = pc_q + PC_W'(4);
    end
  end

  // Fetch FSM, PC and in-flight drop tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        REQ: begin
          if (imem_gnt) begin
            state_q <= WAIT;
            drop_q  <= redirect;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            drop_q  <= 1'b0;
            state_q <= skid_push ? HOLD : REQ;
          end else if (redirect) begin
            drop_q <= 1'b1;
          end
        end
        HOLD: begin
          // Skid is empty next cycle if it pops or is cleared now.
          if (!stall || skid_clr) begin
            state_q <= REQ;
          end
        end
        default: state_q <= REQ;
      endcase
    end
  end

  // Request is held low throughout reset even though the state already reads REQ.
  assign imem_req  = (state_q == REQ) && rst_n;
  assign imem_addr = {pc_q[PC_W-1:2], 2'b00};

  fetch_skid_buf #(
    .PC_W (PC_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .clear_i (skid_clr),
    .instr_i (imem_rdata),
    .pc_i    (pc_q),
    .full_o  (skid_full),
    .instr_o (skid_instr),
    .pc_o    (skid_pc)
  );

  // IF/ID register: flush > stall > skid drain > fresh word > bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      instr_q  <= NOP_INSTR;
      if_pc_q  <= '0;
      if_pc4_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (stall) begin
      valid_q <= valid_q;
    end else if (skid_pop) begin
      valid_q  <= 1'b1;
      instr_q  <= skid_instr;
      if_pc_q  <= skid_pc;
      if_pc4_q <= skid_pc + PC_W'(4);
    end else if (deliver) begin
      valid_q  <= 1'b1;
      instr_q  <= imem_rdata;
      if_pc_q  <= pc_q;
      if_pc4_q <= pc_q + PC_W'(4);
    end else begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end
  end

  assign if_id_valid = valid_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = if_pc_q;
  assign if_id_pc4   = if_pc4_q;
  assign opcode      = instr_q[31:26];
  assign funct       = instr_q[5:0];

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  // Free-running wrap-around counters of kept words and stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (deliver) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (stall)   perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule
